// File: rtl/uart_pkg.sv
// Shared UART definitions: sampler FSM encoding plus divisor, centre, vote and parity helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Clocks per oversample tick; never below one so the tick counter stays meaningful.
    function automatic int uart_div(input int clk_freq, input int baud, input int os);
        int d;
        d = clk_freq / (baud * os);
        return (d < 1) ? 1 : d;
    endfunction

    function automatic int uart_centre(input int os);
        return os / 2;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Expected parity bit for a zero-extended payload; odd=1 selects odd parity.
    function automatic logic parity_bit(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// First-word-fall-through synchronous FIFO; power-of-two depth, pointers wrap naturally.
module uart_rx_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           din,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_fire_s;
    logic             rd_fire_s;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign rd_fire_s = rd_en && !empty;
    assign wr_fire_s = wr_en && (!full || rd_fire_s);
    assign count     = count_q;
    assign dout      = empty ? '0 : mem_q[rd_ptr_q];

    // Pointer and fill-level next state
    always_comb begin
        wr_ptr_d = wr_fire_s ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_fire_s ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({wr_fire_s, rd_fire_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and fill-level registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since dout is masked while empty
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// UART receiver with oversampled majority-vote sampler, receive FIFO, RTS and error pulses.
// Optional parity bit after the payload is enabled by defining UART_RX_PARITY_EN.
module uart_rx_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_FREQ      = 12000000,
    parameter int BAUD_RATE     = 115200,
    parameter int OVERSAMPLE    = 16,
    parameter int DATA_BITS     = 8,
    parameter int STOP_BITS     = 1,
    parameter int FIFO_DEPTH    = 8,
    parameter int RTS_THRESHOLD = 6
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD    = 1'b0
`endif
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          data_out,
    output logic                          data_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          rts,
    output logic                          frame_error,
    output logic                          overrun,
    output logic                          parity_error
);

    localparam int DIV    = uart_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int TW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW     = $clog2(OVERSAMPLE);
    localparam int CENTRE = uart_centre(OVERSAMPLE);
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_PRE     = SW'(CENTRE - 1);
    localparam logic [SW-1:0] S_MID     = SW'(CENTRE);
    localparam logic [SW-1:0] S_POST    = SW'(CENTRE + 1);
    localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    logic                 rx_meta_q, rx_sync_q;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic                 tick_s, tick_clr_s;
    uart_state_e          state_q, state_d;
    logic [SW-1:0]        s_q, s_d;
    logic [1:0]           samp_q, samp_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 par_bad_q, par_bad_d;
    logic                 maj_s, decide_s;
    logic                 wr_req_s, ferr_s, perr_s, ovr_s;
    logic                 rd_fire_s, fifo_wr_s, fifo_full_s, fifo_empty_s;
    logic [CW-1:0]        fifo_count_s;
    logic                 frame_error_q, overrun_q, rts_q;

    // Two-flop synchroniser on the asynchronous line, idle-high
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    assign tick_s   = (tick_cnt_q == TICK_LAST);
    assign maj_s    = majority3(samp_q[0], samp_q[1], rx_sync_q);
    assign decide_s = tick_s && (s_q == S_POST);

    // Free-running tick divider, realigned to the start edge
    always_comb begin
        if (tick_clr_s) begin
            tick_cnt_d = '0;
        end else if (tick_s) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
        end
    end

    // Sampler FSM next state; vote is resolved on the tick after the centre sample
    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        samp_d     = samp_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        stop_cnt_d = stop_cnt_q;
        par_bad_d  = par_bad_q;
        tick_clr_s = 1'b0;
        wr_req_s   = 1'b0;
        ferr_s     = 1'b0;
        perr_s     = 1'b0;

        if ((state_q != ST_IDLE) && tick_s) begin
            s_d       = (s_q == S_LAST) ? '0 : s_q + 1'b1;
            samp_d[0] = (s_q == S_PRE) ? rx_sync_q : samp_q[0];
            samp_d[1] = (s_q == S_MID) ? rx_sync_q : samp_q[1];
        end else begin
            s_d = s_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (!rx_sync_q) begin
                    state_d    = ST_START;
                    s_d        = '0;
                    tick_clr_s = 1'b1;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    par_bad_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (decide_s) begin
                    state_d = maj_s ? ST_IDLE : ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (decide_s) begin
                    shift_d = {maj_s, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d   = ST_PARITY;
`else
                        state_d   = ST_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (decide_s) begin
                    par_bad_d = (maj_s != parity_bit(9'(shift_q), PARITY_ODD));
                    state_d   = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (decide_s) begin
                    if (!maj_s) begin
                        state_d = ST_IDLE;
                        perr_s  = par_bad_q;
                        ferr_s  = !par_bad_q;
                    end else if (stop_cnt_q == STOP_LAST) begin
                        state_d  = ST_IDLE;
                        perr_s   = par_bad_q;
                        wr_req_s = !par_bad_q;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sampler state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_q <= '0;
            state_q    <= ST_IDLE;
            s_q        <= '0;
            samp_q     <= 2'b11;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            stop_cnt_q <= 1'b0;
            par_bad_q  <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            state_q    <= state_d;
            s_q        <= s_d;
            samp_q     <= samp_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            stop_cnt_q <= stop_cnt_d;
            par_bad_q  <= par_bad_d;
        end
    end

    // A same-cycle pop makes room, so a full FIFO only overruns without one
    assign rd_fire_s = rd_en && !fifo_empty_s;
    assign fifo_wr_s = wr_req_s && (!fifo_full_s || rd_fire_s);
    assign ovr_s     = wr_req_s && fifo_full_s && !rd_fire_s;

    uart_rx_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr_en (fifo_wr_s),
        .din   (shift_q),
        .rd_en (rd_en),
        .dout  (data_out),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Registered status: error pulses with parity > frame > overrun, and RTS from fill level
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
            rts_q         <= 1'b0;
        end else begin
            frame_error_q <= ferr_s && !perr_s;
            overrun_q     <= ovr_s && !perr_s && !ferr_s;
            rts_q         <= (fifo_count_s >= CW'(RTS_THRESHOLD));
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_error_q;

    // Parity mismatch pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_error_q <= 1'b0;
        end else begin
            parity_error_q <= perr_s;
        end
    end

    assign parity_error = parity_error_q;
`else
    assign parity_error = 1'b0;
`endif

    assign data_valid  = !fifo_empty_s;
    assign fifo_count  = fifo_count_s;
    assign rts         = rts_q;
    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Self-checking bench for uart_rx_fifo_ctrl: serial frames driven bit by bit, a byte queue as reference.
module tb_uart_rx_fifo_ctrl;

    localparam int BIT_CLKS  = (12000000 / (115200 * 16)) * 16;
    localparam int DEPTH     = 8;
    localparam int THRESHOLD = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       rd_en;
    logic [7:0] data_out;
    logic       data_valid;
    logic [3:0] fifo_count;
    logic       rts;
    logic       frame_error;
    logic       overrun;
    logic       parity_error;

    int n_assert = 0;
    int n_fail   = 0;
    int ferr_seen = 0;
    int ovr_seen  = 0;
    int perr_seen = 0;
    logic [7:0] model_q[$];

    always #5 clk = ~clk;

    uart_rx_fifo_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .rd_en        (rd_en),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .fifo_count   (fifo_count),
        .rts          (rts),
        .frame_error  (frame_error),
        .overrun      (overrun),
        .parity_error (parity_error)
    );

    always @(negedge clk) begin
        if (frame_error === 1'b1) ferr_seen++;
        if (overrun === 1'b1) ovr_seen++;
        if (parity_error === 1'b1) perr_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        @(negedge clk);
        rx = v;
        repeat (BIT_CLKS - 1) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        @(negedge clk);
        rx = 1'b1;
        repeat (n * BIT_CLKS - 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`endif
        send_bit(stop_v);
    endtask

    task automatic pop();
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        int f0;
        int o0;
        int p0;
        int exp_ovr;
        logic [7:0] b;
        logic [7:0] first_b;

        reset = 1'b1;
        rx    = 1'b1;
        rd_en = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_rts", 32'(rts), 32'd0);
        check("rst_pulses", 32'({frame_error, overrun, parity_error}), 32'd0);
        reset = 1'b0;
        idle_bits(1);

        // back-to-back 0x55, 0xA3
        f0 = ferr_seen; o0 = ovr_seen; p0 = perr_seen;
        send_frame(8'h55, 1'b1, 1'b0);
        send_frame(8'hA3, 1'b1, 1'b0);
        idle_bits(1);
        check("b2b_count", 32'(fifo_count), 32'd2);
        check("b2b_head0", 32'(data_out), 32'h55);
        pop();
        check("b2b_head1", 32'(data_out), 32'hA3);
        pop();
        check("b2b_empty", 32'(data_valid), 32'd0);
        check("b2b_errors", 32'((ferr_seen - f0) + (ovr_seen - o0) + (perr_seen - p0)), 32'd0);

        // 0.3-bit glitch, then a normal frame
        f0 = ferr_seen;
        @(negedge clk);
        rx = 1'b0;
        repeat ((BIT_CLKS * 3) / 10) @(negedge clk);
        rx = 1'b1;
        idle_bits(2);
        check("glitch_count", 32'(fifo_count), 32'd0);
        check("glitch_ferr", 32'(ferr_seen - f0), 32'd0);
        b = 8'($urandom_range(0, 255));
        send_frame(b, 1'b1, 1'b0);
        idle_bits(1);
        check("post_glitch_head", 32'(data_out), 32'(b));
        pop();

        // bad stop bit
        f0 = ferr_seen;
        send_frame(8'h3C, 1'b0, 1'b0);
        idle_bits(2);
        check("stop0_ferr", 32'(ferr_seen - f0), 32'd1);
        check("stop0_count", 32'(fifo_count), 32'd0);

        // fill past capacity with no reads
        o0 = ovr_seen;
        exp_ovr = 0;
        first_b = 8'h00;
        for (int k = 0; k < DEPTH + 1; k++) begin
            b = 8'($urandom_range(0, 255));
            if (k == 0) first_b = b;
            send_frame(b, 1'b1, 1'b0);
            idle_bits(1);
            if (model_q.size() < DEPTH) model_q.push_back(b);
            else exp_ovr++;
            check("fill_count", 32'(fifo_count), 32'(model_q.size()));
            check("fill_rts", 32'(rts), 32'(model_q.size() >= THRESHOLD));
        end
        check("fill_overrun", 32'(ovr_seen - o0), 32'(exp_ovr));
        check("fill_head", 32'(data_out), 32'(first_b));
        while (model_q.size() > 0) begin
            check("drain_head", 32'(data_out), 32'(model_q.pop_front()));
            pop();
        end
        repeat (2) @(negedge clk);
        check("drain_valid", 32'(data_valid), 32'd0);
        check("drain_rts", 32'(rts), 32'd0);

        // reset in the middle of the data bits of 0xF0
        b = 8'($urandom_range(0, 255));
        send_frame(b, 1'b1, 1'b0);
        idle_bits(1);
        check("prerst_count", 32'(fifo_count), 32'd1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        @(negedge clk);
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_valid", 32'(data_valid), 32'd0);
        check("midrst_count", 32'(fifo_count), 32'd0);
        check("midrst_data", 32'(data_out), 32'd0);
        check("midrst_rts", 32'(rts), 32'd0);
        check("midrst_pulses", 32'({frame_error, overrun, parity_error}), 32'd0);
        reset = 1'b0;
        idle_bits(2);
        f0 = ferr_seen;
        send_frame(8'h12, 1'b1, 1'b0);
        idle_bits(1);
        check("postrst_count", 32'(fifo_count), 32'd1);
        check("postrst_head", 32'(data_out), 32'h12);
        check("postrst_ferr", 32'(ferr_seen - f0), 32'd0);
        pop();

        // random traffic with random reads
        for (int k = 0; k < 6; k++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(b, 1'b1, 1'b0);
            idle_bits(1);
            model_q.push_back(b);
            check("rand_count", 32'(fifo_count), 32'(model_q.size()));
            if ($urandom_range(0, 1) == 1) begin
                check("rand_head", 32'(data_out), 32'(model_q.pop_front()));
                pop();
            end
        end
        while (model_q.size() > 0) begin
            check("rand_drain", 32'(data_out), 32'(model_q.pop_front()));
            pop();
        end
        check("rand_empty", 32'(data_valid), 32'd0);

`ifdef UART_RX_PARITY_EN
        // even parity: 0x07 needs parity bit 1
        p0 = perr_seen;
        send_frame(8'h07, 1'b1, 1'b1);
        idle_bits(1);
        check("par_bad_pulse", 32'(perr_seen - p0), 32'd1);
        check("par_bad_count", 32'(fifo_count), 32'd0);
        send_frame(8'h07, 1'b1, 1'b0);
        idle_bits(1);
        check("par_ok_head", 32'(data_out), 32'h07);
        check("par_ok_pulse", 32'(perr_seen - p0), 32'd1);
        pop();
`else
        check("noparity_pulses", 32'(perr_seen), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
